pan_stream_tx: RTL



---
 rtl/pan_stream_tx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/pan_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pan_stream_tx
//  Description : Transmit end of the PAN digit stream. Accepts one BCD PAN per
//                load, validates it, then emits start, one digit_valid pulse
//                per digit (GAP idle cycles apart), and pan_end/done. cancel
//                aborts the frame in progress.
//                Optional feature macro: LUHN_APPEND_EN. When defined,
//                pan_len_in is the payload length and a Luhn check digit is
//                appended as the final digit.
//  Revision    : 1.0  initial release
// ============================================================================
module pan_stream_tx #(
    parameter int GAP     = 0,
    parameter int MIN_LEN = 12,
    parameter int MAX_LEN = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [75:0] pan_bcd_in,
    input  logic [4:0]  pan_len_in,
    input  logic        cancel,
    output logic        start,
    output logic        digit_valid,
    output logic [3:0]  digit_in,
    output logic        pan_end,
    output logic        abort,
    output logic        busy,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DIGIT = 3'd2,
        S_GAP   = 3'd3,
        S_END   = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    localparam logic [5:0] MIN_LEN_L = 6'(MIN_LEN);
    localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);
    localparam logic [3:0] GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [75:0] bcd_q, bcd_d;
    logic [4:0]  len_q, len_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic        start_q, start_d;
    logic        digit_valid_q, digit_valid_d;
    logic [3:0]  digit_in_q, digit_in_d;
    logic        pan_end_q, pan_end_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;

    logic [5:0]  load_total;
    logic [5:0]  frame_total;
    logic        load_digits_ok;
    logic [3:0]  next_digit;

`ifdef LUHN_APPEND_EN
    logic [3:0]  luhn_q, luhn_d;
    logic [3:0]  raw_digit;
    logic [3:0]  weighted_digit;
    logic [3:0]  check_digit;
    logic [4:0]  luhn_sum;
    logic [3:0]  luhn_next;

    assign load_total  = {1'b0, pan_len_in} + 6'd1;
    assign frame_total = {1'b0, len_q} + 6'd1;

    // Running Luhn sum and the digit to send next (payload or check digit)
    always_comb begin
        raw_digit = bcd_q[{idx_q, 2'b00} +: 4];
        // position p = len - idx is odd exactly when the low bits differ
        if (len_q[0] ^ idx_q[0]) begin
            if (raw_digit > 4'd4) begin
                weighted_digit = 4'({raw_digit, 1'b0} - 5'd9);
            end else begin
                weighted_digit = {raw_digit[2:0], 1'b0};
            end
        end else begin
            weighted_digit = raw_digit;
        end
        luhn_sum  = {1'b0, luhn_q} + {1'b0, weighted_digit};
        luhn_next = (luhn_sum >= 5'd10) ? 4'(luhn_sum - 5'd10) : luhn_sum[3:0];
        check_digit = (luhn_q == 4'd0) ? 4'd0 : 4'd10 - luhn_q;
        next_digit  = (idx_q == len_q) ? check_digit : raw_digit;
    end
`else
    assign load_total  = {1'b0, pan_len_in};
    assign frame_total = {1'b0, len_q};
    assign next_digit  = bcd_q[{idx_q, 2'b00} +: 4];
`endif

    // Every supplied digit must be BCD
    always_comb begin
        load_digits_ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if ((5'(i) < pan_len_in) && (pan_bcd_in[4*i +: 4] > 4'd9)) begin
                load_digits_ok = 1'b0;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        bcd_d         = bcd_q;
        len_d         = len_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        start_d       = 1'b0;
        digit_valid_d = 1'b0;
        digit_in_d    = 4'd0;
        pan_end_d     = 1'b0;
        abort_d       = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        load_err_d    = 1'b0;
`ifdef LUHN_APPEND_EN
        luhn_d        = luhn_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load && !cancel) begin
                    if ((load_total >= MIN_LEN_L) && (load_total <= MAX_LEN_L) && load_digits_ok) begin
                        state_d = S_START;
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                        bcd_d   = pan_bcd_in;
                        len_d   = pan_len_in;
                        idx_d   = 5'd0;
                        gap_d   = 4'd0;
`ifdef LUHN_APPEND_EN
                        luhn_d  = 4'd0;
`endif
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            S_START, S_DIGIT, S_GAP, S_END: begin
                busy_d = 1'b1;
                if (cancel) begin
                    state_d = S_ABORT;
                    abort_d = 1'b1;
                end else if (state_q == S_END) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if ((state_q == S_DIGIT) && ({1'b0, idx_q} == frame_total)) begin
                    state_d   = S_END;
                    pan_end_d = 1'b1;
                    done_d    = 1'b1;
                end else if ((state_q == S_DIGIT) && (GAP > 0)) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                end else if ((state_q == S_GAP) && (gap_q != 4'd0)) begin
                    gap_d = gap_q - 4'd1;
                end else begin
                    state_d       = S_DIGIT;
                    digit_valid_d = 1'b1;
                    digit_in_d    = next_digit;
                    idx_d         = idx_q + 5'd1;
`ifdef LUHN_APPEND_EN
                    luhn_d        = luhn_next;
`endif
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset silently drops any frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bcd_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            gap_q         <= '0;
            start_q       <= 1'b0;
            digit_valid_q <= 1'b0;
            digit_in_q    <= 4'd0;
            pan_end_q     <= 1'b0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_err_q    <= 1'b0;
`ifdef LUHN_APPEND_EN
            luhn_q        <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            start_q       <= start_d;
            digit_valid_q <= digit_valid_d;
            digit_in_q    <= digit_in_d;
            pan_end_q     <= pan_end_d;
            abort_q       <= abort_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            load_err_q    <= load_err_d;
`ifdef LUHN_APPEND_EN
            luhn_q        <= luhn_d;
`endif
        end
    end

    assign start       = start_q;
    assign digit_valid = digit_valid_q;
    assign digit_in    = digit_in_q;
    assign pan_end     = pan_end_q;
    assign abort       = abort_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign load_err    = load_err_q;

endmodule
`default_nettype wire
